// File: rtl/mips_arb_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    // Address/bus multiplexer select encoding: input A carries the IF address, B the DM address.
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access watchdog: cleared when an access is granted, counts busy cycles without an ack,
// and flags expiry on the cycle the count would reach TIMEOUT. TIMEOUT = 0 disables it.
module arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset_n, clear, enable};
            assign expire        = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else if (clear) begin
                    cnt_q <= '0;
                end else if (enable) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // The ack-less cycle holding count TIMEOUT-1 is the TIMEOUT-th busy cycle.
            assign expire = enable && (cnt_q == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and data access.
// Optional build macro ARB_RR_EN selects round-robin instead of fixed DM priority.
module mem_port_arbiter
    import mips_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic dm_req,
    input  logic dm_we,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic addr_sel,
    output logic if_done,
    output logic dm_done,
    output logic if_stall,
    output logic dm_stall,
    output logic timeout_err
);

    arb_state_e state_q, state_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       addr_sel_q, addr_sel_d;
    logic       if_done_q, if_done_d;
    logic       dm_done_q, dm_done_d;
    logic       err_q, err_d;
    logic       busy;
    logic       grant_dm;
    logic       cnt_clr;
    logic       cnt_expire;

    assign busy = (state_q != IDLE);

`ifdef ARB_RR_EN
    logic last_served_q, last_served_d;

    // With both requesters present, the one not served most recently wins.
    assign grant_dm = dm_req & (~if_req | (last_served_q == SEL_IF));

    always_comb begin
        last_served_d = last_served_q;
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            last_served_d = addr_sel_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_served_q <= SEL_IF;
        end else begin
            last_served_q <= last_served_d;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clr),
        .enable  (busy & ~mem_ack),
        .expire  (cnt_expire)
    );

    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        addr_sel_d = addr_sel_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_d      = err_q;
        cnt_clr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d    = BUSY_DM;
                    addr_sel_d = SEL_DM;
                    mem_we_d   = dm_we;
                    cnt_clr    = 1'b1;
                end else if (if_req) begin
                    state_d    = BUSY_IF;
                    addr_sel_d = SEL_IF;
                    mem_we_d   = 1'b0;
                    cnt_clr    = 1'b1;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An ack in the expiry cycle still completes the access.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_we_d  = 1'b0;
                    if_done_d = (state_q == BUSY_IF);
                    dm_done_d = (state_q == BUSY_DM);
                end else if (cnt_expire) begin
                    state_d  = IDLE;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        mem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= SEL_IF;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_sel_q <= addr_sel_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            err_q      <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign addr_sel    = addr_sel_q;
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign timeout_err = err_q;

    // Stalls release combinationally in the completion cycle.
    assign if_stall = if_req & ~if_done_q;
    assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4; expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

    logic clk, reset_n;
    logic if_req, dm_req, dm_we, mem_ack;
    logic mem_req, mem_we, addr_sel, if_done, dm_done, if_stall, dm_stall, timeout_err;
    logic [4:0] outs;
    int n_cmp, n_fail;

    assign outs = {mem_req, mem_we, addr_sel, if_done, dm_done};

    mem_port_arbiter #(
        .TIMEOUT (4),
        .CNT_W   (5)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .if_done     (if_done),
        .dm_done     (dm_done),
        .if_stall    (if_stall),
        .dm_stall    (dm_stall),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // outs = {mem_req, mem_we, addr_sel, if_done, dm_done}
    task automatic test_reset();
        reset_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; mem_ack = 1'b0;
        #12;
        n_cmp++; if (outs !== 5'b00000) begin n_fail++; $display("FAIL reset_outs got %b want 00000", outs); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", timeout_err); end
        n_cmp++; if ({if_stall, dm_stall} !== 2'b11) begin n_fail++; $display("FAIL reset_stalls got %b want 11", {if_stall, dm_stall}); end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b00000) begin n_fail++; $display("FAIL post_reset_outs got %b want 00000", outs); end
    endtask

    task automatic test_if_read();
        if_req = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b10000) begin n_fail++; $display("FAIL ifrd_c1 got %b want 10000", outs); end
        n_cmp++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL ifrd_stall_c1 got %b want 1", if_stall); end
        step();
        n_cmp++; if (outs !== 5'b10000) begin n_fail++; $display("FAIL ifrd_c2 got %b want 10000", outs); end
        step();
        n_cmp++; if (outs !== 5'b10000) begin n_fail++; $display("FAIL ifrd_c3 got %b want 10000", outs); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (outs !== 5'b00010) begin n_fail++; $display("FAIL ifrd_done got %b want 00010", outs); end
        n_cmp++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL ifrd_stall_done got %b want 0", if_stall); end
        if_req = 1'b0;
        step();
        n_cmp++; if (outs !== 5'b00000) begin n_fail++; $display("FAIL ifrd_after got %b want 00000", outs); end
    endtask

    task automatic test_priority();
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b11100) begin n_fail++; $display("FAIL prio_dm got %b want 11100", outs); end
        n_cmp++; if ({if_stall, dm_stall} !== 2'b11) begin n_fail++; $display("FAIL prio_stalls got %b want 11", {if_stall, dm_stall}); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (outs !== 5'b00101) begin n_fail++; $display("FAIL prio_dm_done got %b want 00101", outs); end
        n_cmp++; if ({if_stall, dm_stall} !== 2'b10) begin n_fail++; $display("FAIL prio_stalls_done got %b want 10", {if_stall, dm_stall}); end
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        n_cmp++; if (outs !== 5'b10000) begin n_fail++; $display("FAIL prio_if got %b want 10000", outs); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (outs !== 5'b00010) begin n_fail++; $display("FAIL prio_if_done got %b want 00010", outs); end
        if_req = 1'b0;
        step();
        n_cmp++; if (outs !== 5'b00000) begin n_fail++; $display("FAIL prio_idle got %b want 00000", outs); end
    endtask

    task automatic test_grant_order();
        logic exp_sel [4];
`ifdef ARB_RR_EN
        exp_sel = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_sel = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        if_req = 1'b1; dm_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({mem_req, addr_sel} !== {1'b1, exp_sel[i]}) begin n_fail++; $display("FAIL order_grant%0d got %b want %b", i, {mem_req, addr_sel}, {1'b1, exp_sel[i]}); end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            n_cmp++; if ({if_done, dm_done} !== {~exp_sel[i], exp_sel[i]}) begin n_fail++; $display("FAIL order_done%0d got %b want %b", i, {if_done, dm_done}, {~exp_sel[i], exp_sel[i]}); end
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL order_idle got %b want 0", mem_req); end
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1;
        step();
        n_cmp++; if ({mem_req, if_done, dm_done} !== 3'b000) begin n_fail++; $display("FAIL ack_idle got %b want 000", {mem_req, if_done, dm_done}); end
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({mem_req, if_done, dm_done} !== 3'b000) begin n_fail++; $display("FAIL ack_idle2 got %b want 000", {mem_req, if_done, dm_done}); end
    endtask

    task automatic test_ack_at_limit();
        if_req = 1'b1;
        step();
        if_req = 1'b0;
        step();
        step();
        step();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL limit_busy4 got %b want 1", mem_req); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if ({outs, timeout_err} !== 6'b000100) begin n_fail++; $display("FAIL limit_done got %b want 000100", {outs, timeout_err}); end
    endtask

    task automatic test_dm_drop();
        dm_req = 1'b1; dm_we = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b11100) begin n_fail++; $display("FAIL drop_grant got %b want 11100", outs); end
        dm_req = 1'b0; dm_we = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            n_cmp++; if (outs !== 5'b11100) begin n_fail++; $display("FAIL drop_busy%0d got %b want 11100", k, outs); end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (outs !== 5'b00101) begin n_fail++; $display("FAIL drop_done got %b want 00101", outs); end
        step();
        n_cmp++; if (outs !== 5'b00100) begin n_fail++; $display("FAIL drop_after got %b want 00100", outs); end
    endtask

    task automatic test_timeout();
        if_req = 1'b1;
        step();
        if_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++; if ({mem_req, timeout_err} !== 2'b10) begin n_fail++; $display("FAIL tmo_busy%0d got %b want 10", k, {mem_req, timeout_err}); end
            step();
        end
        n_cmp++; if ({outs, timeout_err} !== 6'b000001) begin n_fail++; $display("FAIL tmo_abort got %b want 000001", {outs, timeout_err}); end
        step();
        n_cmp++; if ({outs, timeout_err} !== 6'b000001) begin n_fail++; $display("FAIL tmo_sticky got %b want 000001", {outs, timeout_err}); end
        dm_req = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b10100) begin n_fail++; $display("FAIL tmo_next_grant got %b want 10100", outs); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        n_cmp++; if ({outs, timeout_err} !== 6'b001011) begin n_fail++; $display("FAIL tmo_next_done got %b want 001011", {outs, timeout_err}); end
        step();
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b1;
        step();
        n_cmp++; if (outs !== 5'b11100) begin n_fail++; $display("FAIL rmid_grant got %b want 11100", outs); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({outs, timeout_err} !== 6'b000000) begin n_fail++; $display("FAIL rmid_async got %b want 000000", {outs, timeout_err}); end
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if ({outs, timeout_err} !== 6'b000000) begin n_fail++; $display("FAIL rmid_after%0d got %b want 000000", k, {outs, timeout_err}); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_if_read();
        test_priority();
        test_grant_order();
        test_ack_idle();
        test_ack_at_limit();
        test_dm_drop();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
